// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Package     : div_pkg
// Description : Shared types and helpers for the sequential divider.
// Revision    : 1.0
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } div_state_e;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration.
// Revision    : 1.0
// ============================================================================
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_shreg,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_shreg
);

    logic [WIDTH:0] w_partial;
    logic           w_fits;

    // One extra bit holds the shifted-out MSB; the difference itself always fits WIDTH bits.
    assign w_partial = {i_rem, i_shreg[WIDTH-1]};
    assign w_fits    = (w_partial >= {1'b0, i_divisor});
    assign o_rem     = w_fits ? (w_partial[WIDTH-1:0] - i_divisor) : w_partial[WIDTH-1:0];
    assign o_shreg   = {i_shreg[WIDTH-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Multi-cycle signed/unsigned restoring divider, start/done handshake.
// Revision    : 1.0
// ============================================================================
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic             ready,
    output logic             done,
    output logic             dbz
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             smode_q, smode_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] o0_q, o0_d;
    logic [WIDTH-1:0] o1_q, o1_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_shreg;
    logic             w_neg0;
    logic             w_neg1;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (rem_q),
        .i_shreg   (shreg_q),
        .i_divisor (divisor_q),
        .o_rem     (w_step_rem),
        .o_shreg   (w_step_shreg)
    );

    assign w_neg0 = smode_q & shreg_q[WIDTH-1];
    assign w_neg1 = smode_q & divisor_q[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        smode_d   = smode_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        o0_d      = o0_q;
        o1_d      = o1_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        ready_d   = ready_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // The raw dividend stays in shreg so a divide-by-zero can return it untouched.
                    shreg_d   = i0;
                    divisor_d = i1;
                    smode_d   = signed_mode;
                    ready_d   = 1'b0;
                    state_d   = (i1 == '0) ? FIX : PREP;
                end
            end
            PREP: begin
                shreg_d   = w_neg0 ? -shreg_q : shreg_q;
                divisor_d = w_neg1 ? -divisor_q : divisor_q;
                qneg_d    = w_neg0 ^ w_neg1;
                rneg_d    = w_neg0;
                rem_d     = '0;
                cnt_d     = CW'(WIDTH - 1);
                state_d   = CALC;
            end
            CALC: begin
                rem_d   = w_step_rem;
                shreg_d = w_step_shreg;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (divisor_q == '0) begin
                    o0_d  = '1;
                    o1_d  = shreg_q;
                    dbz_d = 1'b1;
                end else begin
                    o0_d  = qneg_q ? -shreg_q : shreg_q;
                    o1_d  = rneg_q ? -rem_q : rem_q;
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            smode_q   <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            o0_q      <= '0;
            o1_q      <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            smode_q   <= smode_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            o0_q      <= o0_d;
            o1_q      <= o1_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign o0    = o0_q;
    assign o1    = o1_q;
    assign dbz   = dbz_q;
    assign done  = done_q;
    assign ready = ready_q;

endmodule
`default_nettype wire
